// File: rtl/uart_console_fifo.sv
// Receive-side console byte FIFO with show-ahead valid/ready output and a stored-line counter.
// Optional build macro UART_CONSOLE_CR_STRIP_EN discards carriage-return bytes on entry.
module uart_console_fifo #(
    parameter int unsigned AW     = 6,
    parameter logic [7:0]  EOL    = 8'h0A,
    parameter int unsigned DROP_W = 16
) (
    input  logic              sys_clk_i,
    input  logic              sys_rst_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_done_i,
    output logic [7:0]        data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [AW:0]       level_o,
    output logic [AW:0]       line_cnt_o,
    output logic              line_ready_o,
    output logic              overflow_o,
    output logic [DROP_W-1:0] drop_cnt_o,
    input  logic              clr_i
);

    localparam int unsigned DEPTH    = 1 << AW;
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    logic [7:0]        mem [DEPTH];
    logic [AW-1:0]     head_q;
    logic [AW-1:0]     tail_q;
    logic [AW:0]       level_q;
    logic [AW:0]       line_q;
    logic              valid_q;
    logic              line_rdy_q;
    logic              ovf_q;
    logic [DROP_W-1:0] drop_q;

    logic              is_cr_c;
    logic              full_c;
    logic              wr_c;
    logic              drop_c;
    logic              rd_c;
    logic [7:0]        head_byte_c;
    logic              wr_eol_c;
    logic              rd_eol_c;
    logic [AW:0]       level_n_c;
    logic [AW:0]       line_n_c;

    // Accept/drop/read decisions; fullness is judged on the pre-cycle level.
    always_comb begin
        is_cr_c     = 1'b0;
`ifdef UART_CONSOLE_CR_STRIP_EN
        is_cr_c     = (rx_data_i == 8'h0D);
`endif
        full_c      = (level_q == LVL_FULL);
        wr_c        = rx_done_i && !is_cr_c && !full_c;
        drop_c      = rx_done_i && !is_cr_c && full_c;
        rd_c        = valid_q && ready_i;
        head_byte_c = mem[head_q];
        wr_eol_c    = wr_c && (rx_data_i == EOL);
        rd_eol_c    = rd_c && (head_byte_c == EOL);

        level_n_c = level_q;
        if (wr_c && !rd_c) begin
            level_n_c = level_q + (AW+1)'(1);
        end else if (rd_c && !wr_c) begin
            level_n_c = level_q - (AW+1)'(1);
        end

        line_n_c = line_q;
        if (wr_eol_c && !rd_eol_c) begin
            line_n_c = line_q + (AW+1)'(1);
        end else if (rd_eol_c && !wr_eol_c) begin
            line_n_c = line_q - (AW+1)'(1);
        end
    end

    // Storage array; no reset needed since contents are only visible through level.
    always_ff @(posedge sys_clk_i) begin
        if (wr_c && !sys_rst_i) begin
            mem[tail_q] <= rx_data_i;
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            head_q     <= '0;
            tail_q     <= '0;
            level_q    <= '0;
            line_q     <= '0;
            valid_q    <= 1'b0;
            line_rdy_q <= 1'b0;
        end else begin
            if (rd_c) begin
                head_q <= head_q + AW'(1);
            end
            if (wr_c) begin
                tail_q <= tail_q + AW'(1);
            end
            level_q    <= level_n_c;
            line_q     <= line_n_c;
            valid_q    <= (level_n_c != '0);
            line_rdy_q <= (line_n_c != '0);
        end
    end

    // Drop tracking: a drop coinciding with clear restarts the count at one.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            ovf_q  <= 1'b0;
            drop_q <= '0;
        end else if (drop_c) begin
            ovf_q <= 1'b1;
            if (clr_i) begin
                drop_q <= DROP_W'(1);
            end else if (!(&drop_q)) begin
                drop_q <= drop_q + DROP_W'(1);
            end
        end else if (clr_i) begin
            ovf_q  <= 1'b0;
            drop_q <= '0;
        end
    end

    assign data_o       = head_byte_c;
    assign valid_o      = valid_q;
    assign level_o      = level_q;
    assign line_cnt_o   = line_q;
    assign line_ready_o = line_rdy_q;
    assign overflow_o   = ovf_q;
    assign drop_cnt_o   = drop_q;

endmodule

// File: tb/tb_uart_console_fifo.sv
// Directed bench for uart_console_fifo (AW=6) with a byte-queue reference for read ordering.
module tb_uart_console_fifo;

    localparam int unsigned AW     = 6;
    localparam int unsigned DROP_W = 16;

    logic              sys_clk = 1'b0;
    logic              sys_rst;
    logic [7:0]        rx_data;
    logic              rx_done;
    logic [7:0]        data;
    logic              valid;
    logic              ready;
    logic [AW:0]       level;
    logic [AW:0]       line_cnt;
    logic              line_ready;
    logic              overflow;
    logic [DROP_W-1:0] drop_cnt;
    logic              clr;

    int n_assert = 0;
    int n_fail   = 0;
    logic [7:0] q[$];

    uart_console_fifo #(.AW(AW), .EOL(8'h0A), .DROP_W(DROP_W)) dut (
        .sys_clk_i    (sys_clk),
        .sys_rst_i    (sys_rst),
        .rx_data_i    (rx_data),
        .rx_done_i    (rx_done),
        .data_o       (data),
        .valid_o      (valid),
        .ready_i      (ready),
        .level_o      (level),
        .line_cnt_o   (line_cnt),
        .line_ready_o (line_ready),
        .overflow_o   (overflow),
        .drop_cnt_o   (drop_cnt),
        .clr_i        (clr)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_lines();
        int n = 0;
        foreach (q[i]) if (q[i] == 8'h0A) n++;
        return n;
    endfunction

    // One clock with optional write and read; checks the output byte against the reference queue.
    task automatic cycle(input logic wr, input logic [7:0] d, input logic rdy);
        bit full_pre;
        bit cr;
        rx_done  = wr;
        rx_data  = d;
        ready    = rdy;
        full_pre = (q.size() == 64);
        check("valid", 32'(valid), 32'(q.size() != 0));
        if (valid && rdy && q.size() != 0) begin
            check("rd_data", 32'(data), 32'(q[0]));
            void'(q.pop_front());
        end
        cr = 1'b0;
`ifdef UART_CONSOLE_CR_STRIP_EN
        cr = (d == 8'h0D);
`endif
        if (wr && !cr && !full_pre) q.push_back(d);
        tick();
        rx_done = 1'b0;
        ready   = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 80 && q.size() != 0; i++) cycle(1'b0, 8'h00, 1'b1);
        check({tag, "_empty_valid"}, 32'(valid), 32'd0);
        check({tag, "_empty_level"}, 32'(level), 32'd0);
        check({tag, "_empty_lines"}, 32'(line_cnt), 32'd0);
    endtask

    initial begin
        sys_rst = 1'b1;
        rx_data = 8'h00;
        rx_done = 1'b0;
        ready   = 1'b0;
        clr     = 1'b0;
        tick();
        tick();
        sys_rst = 1'b0;
        tick();

        check("rst_valid",    32'(valid),      32'd0);
        check("rst_level",    32'(level),      32'd0);
        check("rst_lines",    32'(line_cnt),   32'd0);
        check("rst_line_rdy", 32'(line_ready), 32'd0);
        check("rst_overflow", 32'(overflow),   32'd0);
        check("rst_drop",     32'(drop_cnt),   32'd0);

        // "Hi\n" held back, then drained
        cycle(1'b1, 8'h48, 1'b0);
        check("hi_first_valid", 32'(valid), 32'd1);
        check("hi_first_data",  32'(data),  32'h48);
        cycle(1'b1, 8'h69, 1'b0);
        cycle(1'b1, 8'h0A, 1'b0);
        check("hi_level",    32'(level),      32'd3);
        check("hi_lines",    32'(line_cnt),   32'd1);
        check("hi_line_rdy", 32'(line_ready), 32'd1);
        check("hi_rd0", 32'(data), 32'h48);
        cycle(1'b0, 8'h00, 1'b1);
        check("hi_rd1", 32'(data), 32'h69);
        cycle(1'b0, 8'h00, 1'b1);
        check("hi_rd2", 32'(data), 32'h0A);
        cycle(1'b0, 8'h00, 1'b1);
        check("hi_done_lines", 32'(line_cnt),   32'd0);
        check("hi_done_rdy",   32'(line_ready), 32'd0);
        check("hi_done_valid", 32'(valid),      32'd0);
        cycle(1'b0, 8'h00, 1'b1);
        check("empty_ready_level", 32'(level), 32'd0);

        // Overflow: 70 bytes into 64 slots
        for (int i = 0; i < 70; i++) cycle(1'b1, 8'(i), 1'b0);
        check("ovf_level", 32'(level),    32'd64);
        check("ovf_flag",  32'(overflow), 32'd1);
`ifdef UART_CONSOLE_CR_STRIP_EN
        check("ovf_drop",  32'(drop_cnt), 32'd5);
`else
        check("ovf_drop",  32'(drop_cnt), 32'd6);
`endif
        check("ovf_lines", 32'(line_cnt), 32'd1);
        check("ovf_head",  32'(data),     32'h00);

        // Full with a simultaneous read: write still dropped
        cycle(1'b1, 8'h55, 1'b1);
        check("fullrd_level", 32'(level), 32'd63);
`ifdef UART_CONSOLE_CR_STRIP_EN
        check("fullrd_drop", 32'(drop_cnt), 32'd6);
`else
        check("fullrd_drop", 32'(drop_cnt), 32'd7);
`endif
        drain("ovf");
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_overflow", 32'(overflow), 32'd0);
        check("clr_drop",     32'(drop_cnt), 32'd0);

        // Drop coinciding with clear leaves overflow set and count at one
        for (int i = 0; i < 64; i++) cycle(1'b1, 8'h30, 1'b0);
        cycle(1'b1, 8'h31, 1'b0);
        check("pre_clr_drop", 32'(drop_cnt), 32'd1);
        clr = 1'b1;
        cycle(1'b1, 8'h32, 1'b0);
        check("clrdrop_overflow", 32'(overflow), 32'd1);
        check("clrdrop_drop",     32'(drop_cnt), 32'd1);
        cycle(1'b1, 8'h33, 1'b0);
        clr = 1'b0;
        check("clr_again_overflow", 32'(overflow), 32'd1);
        check("clr_again_drop",     32'(drop_cnt), 32'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr2_drop", 32'(drop_cnt), 32'd0);
        drain("clr");

        // EOL written and EOL read in the same cycle
        cycle(1'b1, 8'h0A, 1'b0);
        cycle(1'b1, 8'h0A, 1'b1);
        check("simul_lines", 32'(line_cnt), 32'd1);
        check("simul_level", 32'(level),    32'd1);
        drain("simul");

        // 200-byte stream across pointer wrap with ready toggling every cycle
        begin
            int sent = 0;
            for (int i = 0; i < 400 && sent < 200; i++) begin
                logic wr;
                wr = ((i % 3) != 2);
                cycle(wr, 8'(sent), 1'(i & 1));
                if (wr) sent++;
                check("stream_level", 32'(level),    32'(q.size()));
                check("stream_lines", 32'(line_cnt), 32'(model_lines()));
            end
            check("stream_sent", 32'(sent), 32'd200);
            check("stream_no_drop", 32'(drop_cnt), 32'd0);
        end
        drain("stream");

        // Reset with a write and read pending in the same cycle
        for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'h20 + 8'(i)), 1'b0);
        check("mid_level", 32'(level), 32'd10);
        sys_rst = 1'b1;
        rx_done = 1'b1;
        rx_data = 8'h77;
        ready   = 1'b1;
        tick();
        sys_rst = 1'b0;
        rx_done = 1'b0;
        ready   = 1'b0;
        q.delete();
        check("midrst_level", 32'(level),    32'd0);
        check("midrst_valid", 32'(valid),    32'd0);
        check("midrst_lines", 32'(line_cnt), 32'd0);
        tick();
        check("midrst_level2", 32'(level), 32'd0);

        // "A\r\n"
        cycle(1'b1, 8'h41, 1'b0);
        cycle(1'b1, 8'h0D, 1'b0);
        cycle(1'b1, 8'h0A, 1'b0);
`ifdef UART_CONSOLE_CR_STRIP_EN
        check("cr_level", 32'(level), 32'd2);
`else
        check("cr_level", 32'(level), 32'd3);
`endif
        check("cr_lines", 32'(line_cnt), 32'd1);
        check("cr_drop",  32'(drop_cnt), 32'd0);
        drain("cr");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
